// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and
// the controller state encoding.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: load lane extraction
// with sign/zero extension, sub-word store merge into a full memory word,
// and the alignment/size legality check for an incoming request.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_offset,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    output logic [31:0] ld_result,
    input  logic [31:0] st_old,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_offset,
    input  logic [1:0]  st_size,
    output logic [31:0] st_merged,
    input  logic [1:0]  chk_offset,
    input  logic [1:0]  chk_size,
    output logic        chk_err
);

    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic uns);
        logic signed [7:0]  sb;
        logic signed [31:0] sw;
        sb = signed'(b);
        sw = sb;
        return uns ? {24'h000000, b} : sw;
    endfunction

    function automatic logic [31:0] extend_half(input logic [15:0] h, input logic uns);
        logic signed [15:0] sh;
        logic signed [31:0] sw;
        sh = signed'(h);
        sw = sh;
        return uns ? {16'h0000, h} : sw;
    endfunction

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Pick the addressed lane of the read word and extend it to 32 bits
    always_comb begin
        case (ld_offset)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            SZ_BYTE: ld_result = extend_byte(ld_byte, ld_unsigned);
            SZ_HALF: ld_result = extend_half(ld_half, ld_unsigned);
            default: ld_result = ld_word;
        endcase
    end

    // Replace the addressed lane of the old word with the low store bytes
    always_comb begin
        st_merged = st_old;
        case (st_size)
            SZ_BYTE: begin
                case (st_offset)
                    2'd0:    st_merged[7:0]   = st_data[7:0];
                    2'd1:    st_merged[15:8]  = st_data[7:0];
                    2'd2:    st_merged[23:16] = st_data[7:0];
                    default: st_merged[31:24] = st_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (st_offset[1]) st_merged[31:16] = st_data[15:0];
                else              st_merged[15:0]  = st_data[15:0];
            end
            default: st_merged = st_data;
        endcase
    end

    // Misaligned half/word or the reserved size encoding is rejected
    always_comb begin
        chk_err = 1'b0;
        case (chk_size)
            SZ_HALF: chk_err = chk_offset[0];
            SZ_WORD: chk_err = (chk_offset != 2'b00);
            SZ_ILL:  chk_err = 1'b1;
            default: chk_err = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time from the pipeline, drives
// a word-addressed data memory without byte enables (sub-word stores use
// read-modify-write) and returns a single response per request.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       ld_result;
    logic [31:0]       st_merged;
    logic              acc_err;
    logic              accept;

    lsu_align u_align (
        .ld_word     (mem_rdata),
        .ld_offset   (addr_q[1:0]),
        .ld_size     (size_q),
        .ld_unsigned (unsigned_q),
        .ld_result   (ld_result),
        .st_old      (merge_q),
        .st_data     (wdata_q),
        .st_offset   (addr_q[1:0]),
        .st_size     (size_q),
        .st_merged   (st_merged),
        .chk_offset  (req_addr[1:0]),
        .chk_size    (req_size),
        .chk_err     (acc_err)
    );

    assign accept = req_valid && (state_q == IDLE);

    // Controller state, latched address and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        rdata_q <= '0;
                        err_q   <= acc_err;
                        if (acc_err)               state_q <= RESP;
                        else if (!req_write)       state_q <= LOAD;
                        else if (req_size == SZ_WORD) state_q <= STORE;
                        else                       state_q <= RMW_RD;
                    end
                end
                LOAD: begin
                    rdata_q <= ld_result;
                    state_q <= RESP;
                end
                STORE:  state_q <= RESP;
                RMW_RD: state_q <= RMW_WR;
                RMW_WR: state_q <= RESP;
                RESP: begin
                    if (rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Request payload and read-modify-write merge word; only consumed under
    // the states that load them, so they need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
        end
        if (state_q == RMW_RD) begin
            merge_q <= mem_rdata;
        end
    end

    // Strobes and write data decoded from the registered state only
    always_comb begin
        mem_wdata = '0;
        case (state_q)
            STORE:   mem_wdata = wdata_q;
            RMW_WR:  mem_wdata = st_merged;
            default: mem_wdata = '0;
        endcase
    end

    assign mem_read  = (state_q == LOAD)  || (state_q == RMW_RD);
    assign mem_write = (state_q == STORE) || (state_q == RMW_WR);
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and a
// scoreboard queue of expected responses.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          reads;
        int          writes;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Word memory: combinational read, write on the rising edge
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
        chk({tag, "_mem_read"},  32'(mem_read), 32'd0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, "_mem_addr"},  mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // Issue one request, observe strobes each cycle until the response,
    // then compare against the scoreboard entry pushed at issue time
    task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                           input int e_reads, input int e_writes, input logic [31:0] e_wdata,
                           input int hold);
        exp_t        e;
        exp_t        got;
        int          lat;
        int          nr;
        int          nw;
        bit          done;
        logic [31:0] last_wd;
        logic [31:0] held;
        e.rdata  = e_rdata;
        e.err    = e_err;
        e.lat    = e_lat;
        e.reads  = e_reads;
        e.writes = e_writes;
        e.wdata  = e_wdata;
        sb_q.push_back(e);

        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        rsp_ready    = (hold == 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;

        lat = 0; nr = 0; nw = 0; done = 1'b0; last_wd = '0;
        while (!done) begin
            @(negedge clk);
            lat++;
            if (mem_read) nr++;
            if (mem_write) begin
                nw++;
                last_wd = mem_wdata;
            end
            if (mem_read || mem_write) begin
                chk({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                chk({tag, "_strobe_excl"}, 32'(mem_read & mem_write), 32'd0);
            end
            if (rsp_valid) done = 1'b1;
            else if (lat >= 8) begin
                chk({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
                done = 1'b1;
            end
        end

        got = sb_q.pop_front();
        chk({tag, "_latency"}, 32'(lat), 32'(got.lat));
        chk({tag, "_rdata"},   rsp_rdata, got.rdata);
        chk({tag, "_err"},     32'(rsp_err), 32'(got.err));
        chk({tag, "_reads"},   32'(nr), 32'(got.reads));
        chk({tag, "_writes"},  32'(nw), 32'(got.writes));
        if (got.writes > 0) chk({tag, "_wdata"}, last_wd, got.wdata);

        if (hold > 0) begin
            held = rsp_rdata;
            repeat (hold) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, "_hold_rdata"}, rsp_rdata, held);
                chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_back_idle"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_drop"},  32'(rsp_valid), 32'd0);
    endtask

    initial begin
        bit seen_wr;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = SZ_WORD;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset");

        // Word store then word load
        run_req("st_w10", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 32'hDEADBEEF, 0);
        run_req("ld_w10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0, 0);

        // Byte store by read-modify-write, then read back
        run_req("st_w20", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 0, 1, 32'h11223344, 0);
        run_req("st_b21", 1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h000000AA, 32'h0, 1'b0, 3, 1, 1, 32'h1122AA44, 0);
        run_req("ld_w20", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h1122AA44, 1'b0, 2, 1, 0, 32'h0, 0);

        // Sub-word loads with extension
        run_req("st_w30",  1'b1, SZ_WORD, 1'b0, 32'h30, 32'h80FF7F01, 32'h0, 1'b0, 2, 0, 1, 32'h80FF7F01, 0);
        run_req("ld_b32s", 1'b0, SZ_BYTE, 1'b0, 32'h32, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 1, 0, 32'h0, 0);
        run_req("ld_b32u", 1'b0, SZ_BYTE, 1'b1, 32'h32, 32'h0, 32'h000000FF, 1'b0, 2, 1, 0, 32'h0, 0);
        run_req("ld_h30s", 1'b0, SZ_HALF, 1'b0, 32'h30, 32'h0, 32'h00007F01, 1'b0, 2, 1, 0, 32'h0, 0);
        run_req("ld_h32s", 1'b0, SZ_HALF, 1'b0, 32'h32, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1, 0, 32'h0, 0);
        run_req("ld_h32u", 1'b0, SZ_HALF, 1'b1, 32'h32, 32'h0, 32'h000080FF, 1'b0, 2, 1, 0, 32'h0, 0);
        run_req("ld_b33s", 1'b0, SZ_BYTE, 1'b0, 32'h33, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0, 0);
        run_req("ld_b31u", 1'b0, SZ_BYTE, 1'b1, 32'h31, 32'h0, 32'h0000007F, 1'b0, 2, 1, 0, 32'h0, 0);

        // Errors: no memory access, response one cycle after accept
        run_req("err_ldw13", 1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 0);
        run_req("err_sth15", 1'b1, SZ_HALF, 1'b0, 32'h15, 32'h0000BEEF, 32'h0, 1'b1, 1, 0, 0, 32'h0, 0);
        run_req("err_ld_sz3", 1'b0, SZ_ILL, 1'b0, 32'h30, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 0);
        run_req("err_st_sz3", 1'b1, SZ_ILL, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0, 0, 32'h0, 0);
        run_req("ld_w20_kept", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h1122AA44, 1'b0, 2, 1, 0, 32'h0, 0);

        // Response held while rsp_ready stays low
        run_req("hold_ld_w10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0, 5);

        // Upper half store merges into the existing word
        run_req("st_h22", 1'b1, SZ_HALF, 1'b0, 32'h22, 32'h1234BEEF, 32'h0, 1'b0, 3, 1, 1, 32'hBEEFAA44, 0);
        run_req("ld_w20_h", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0, 2, 1, 0, 32'h0, 0);

        // Asynchronous reset during RMW_WR abandons the write
        run_req("st_w40", 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h55667788, 32'h0, 1'b0, 2, 0, 1, 32'h55667788, 0);
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = SZ_BYTE;
        req_unsigned = 1'b0;
        req_addr     = 32'h41;
        req_wdata    = 32'h00000099;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen_wr = 1'b0;
        for (int i = 0; i < 6 && !seen_wr; i++) begin
            @(negedge clk);
            if (mem_write) seen_wr = 1'b1;
        end
        chk("rst_mid_reached_wr", 32'(seen_wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_mem_kept", mem[16], 32'h55667788);
        chk_reset_outputs("rst_mid_hold");
        rst_n = 1'b1;
        @(negedge clk);
        run_req("ld_w40", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h55667788, 1'b0, 2, 1, 0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
